// File: rtl/pwm_multicanal_pkg.sv
// rtl/pwm_multicanal_pkg.sv - shared mode encodings, default period and index width helper
package pwm_multicanal_pkg;

   typedef enum logic {
      MODO_BORDE    = 1'b0,
      MODO_CENTRADO = 1'b1
   } modo_t;

   localparam int PERIODO_DEF = 499_999;

   // Channel-index width, never below one bit so a single-channel build still has a port.
   function automatic int ancho_canal(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pwm_canal.sv
// rtl/pwm_canal.sv - one PWM channel: shadow/active duty pair and registered compare
module pwm_canal #(
   parameter int ANCHO = 19
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             en,
   input  logic [ANCHO-1:0] cuenta,
   input  logic             frontera,
   input  logic             wr_en,
   input  logic [ANCHO-1:0] wr_duty,
   output logic             pwm,
   output logic             difiere
);

   logic [ANCHO-1:0] sombra;
   logic [ANCHO-1:0] activo;
   logic [ANCHO-1:0] sombra_sig;

   // The active duty loads the post-write shadow so a boundary-cycle write lands in the same update.
   assign sombra_sig = wr_en ? wr_duty : sombra;
   assign difiere    = (sombra != activo);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sombra <= '0;
         activo <= '0;
         pwm    <= 1'b0;
      end else begin
         sombra <= sombra_sig;
         if (frontera) begin
            activo <= sombra_sig;
         end
         pwm <= en && (cuenta < activo);
      end
   end

endmodule

// File: rtl/pwm_multicanal.sv
// rtl/pwm_multicanal.sv - shared period counter driving N double-buffered PWM channels
module pwm_multicanal
   import pwm_multicanal_pkg::*;
#(
   parameter int N_CANALES   = 4,
   parameter int ANCHO       = 19,
   parameter int PERIODO_RST = PERIODO_DEF
) (
   input  logic                                  CLK,
   input  logic                                  RST_N,
   input  logic                                  EN,
   input  logic [ANCHO-1:0]                      PERIODO,
   input  logic                                  CENTRADO,
   input  logic                                  WR_EN,
   input  logic [ancho_canal(N_CANALES)-1:0]     WR_CANAL,
   input  logic [ANCHO-1:0]                      WR_DUTY,
   output logic [N_CANALES-1:0]                  PWM_OUT,
   output logic                                  CICLO,
   output logic                                  PENDIENTE
);

   logic [ANCHO-1:0]     cuenta;
   logic [ANCHO-1:0]     periodo_act;
   modo_t                modo_act;
   logic                 bajando;
   logic                 frontera;
   logic [N_CANALES-1:0] difiere;

   // P == 1 in centre mode never counts down, so count 1 going up closes that period.
   always_comb begin
      frontera = 1'b0;
      if (!EN) begin
         frontera = 1'b1;
      end else if (modo_act == MODO_BORDE) begin
         frontera = (cuenta == periodo_act);
      end else begin
         frontera = (periodo_act == '0) ||
                    ((cuenta == ANCHO'(1)) && (bajando || (periodo_act == ANCHO'(1))));
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cuenta      <= '0;
         bajando     <= 1'b0;
         periodo_act <= ANCHO'(PERIODO_RST);
         modo_act    <= MODO_BORDE;
         CICLO       <= 1'b0;
         PENDIENTE   <= 1'b0;
      end else begin
         CICLO     <= EN && (cuenta == '0);
         PENDIENTE <= |difiere;
         if (frontera) begin
            cuenta      <= '0;
            bajando     <= 1'b0;
            periodo_act <= PERIODO;
            modo_act    <= modo_t'(CENTRADO);
         end else if (modo_act == MODO_BORDE) begin
            cuenta <= cuenta + ANCHO'(1);
         end else if (bajando) begin
            cuenta <= cuenta - ANCHO'(1);
         end else if (cuenta == periodo_act) begin
            bajando <= 1'b1;
            cuenta  <= cuenta - ANCHO'(1);
         end else begin
            cuenta <= cuenta + ANCHO'(1);
         end
      end
   end

   for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
      pwm_canal #(
         .ANCHO(ANCHO)
      ) u_canal (
         .CLK      (CLK),
         .RST_N    (RST_N),
         .en       (EN),
         .cuenta   (cuenta),
         .frontera (frontera),
         .wr_en    (WR_EN && (int'(WR_CANAL) == i)),
         .wr_duty  (WR_DUTY),
         .pwm      (PWM_OUT[i]),
         .difiere  (difiere[i])
      );
   end

endmodule

// File: tb/tb_pwm_multicanal.sv
// tb/tb_pwm_multicanal.sv - directed self-checking bench for pwm_multicanal
module tb_pwm_multicanal;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        EN;
   logic [18:0] PERIODO;
   logic        CENTRADO;
   logic        WR_EN;
   logic [1:0]  WR_CANAL;
   logic [18:0] WR_DUTY;
   logic [3:0]  PWM_OUT;
   logic        CICLO;
   logic        PENDIENTE;

   int errores = 0;
   int checks  = 0;

   pwm_multicanal #(
      .N_CANALES   (4),
      .ANCHO       (19),
      .PERIODO_RST (499_999)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .EN        (EN),
      .PERIODO   (PERIODO),
      .CENTRADO  (CENTRADO),
      .WR_EN     (WR_EN),
      .WR_CANAL  (WR_CANAL),
      .WR_DUTY   (WR_DUTY),
      .PWM_OUT   (PWM_OUT),
      .CICLO     (CICLO),
      .PENDIENTE (PENDIENTE)
   );

   always #5 CLK = ~CLK;

   task automatic step;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic escribir(input int canal, input int duty);
      WR_EN    = 1'b1;
      WR_CANAL = 2'(canal);
      WR_DUTY  = 19'(duty);
      step();
      WR_EN    = 1'b0;
   endtask

   task automatic reiniciar;
      EN = 1'b0;
      step();
      EN = 1'b1;
      step();
   endtask

   task automatic test_reset;
      RST_N = 1'b0; EN = 1'b0; PERIODO = 19'd9; CENTRADO = 1'b0;
      WR_EN = 1'b0; WR_CANAL = 2'd0; WR_DUTY = 19'd0;
      repeat (3) step();
      checks++; if (PWM_OUT !== 4'b0000) begin errores++; $display("FAIL reset_pwm got=%b exp=0000", PWM_OUT); end
      checks++; if (CICLO !== 1'b0) begin errores++; $display("FAIL reset_ciclo got=%b exp=0", CICLO); end
      checks++; if (PENDIENTE !== 1'b0) begin errores++; $display("FAIL reset_pend got=%b exp=0", PENDIENTE); end
      RST_N = 1'b1;
      step();
   endtask

   // P=9 edge mode, ch0 D=3 written while disabled
   task automatic test_borde;
      logic e;
      escribir(0, 3);
      reiniciar();
      for (int k = 0; k < 30; k++) begin
         e = (k % 10) < 3;
         checks++; if (PWM_OUT[0] !== e) begin errores++; $display("FAIL borde_pwm0 k=%0d got=%b exp=%b", k, PWM_OUT[0], e); end
         e = (k % 10) == 0;
         checks++; if (CICLO !== e) begin errores++; $display("FAIL borde_ciclo k=%0d got=%b exp=%b", k, CICLO, e); end
         step();
      end
   endtask

   task automatic test_escritura;
      logic e;
      reiniciar();
      for (int k = 0; k < 30; k++) begin
         if (k < 10)      e = 1'b0;
         else if (k < 20) e = (k - 10) < 7;
         else             e = (k - 20) < 2;
         checks++; if (PWM_OUT[1] !== e) begin errores++; $display("FAIL escr_pwm1 k=%0d got=%b exp=%b", k, PWM_OUT[1], e); end
         e = (k >= 5) && (k <= 9);
         checks++; if (PENDIENTE !== e) begin errores++; $display("FAIL escr_pend k=%0d got=%b exp=%b", k, PENDIENTE, e); end
         WR_EN = 1'b0;
         if (k == 3)  begin WR_EN = 1'b1; WR_CANAL = 2'd1; WR_DUTY = 19'd7; end
         if (k == 18) begin WR_EN = 1'b1; WR_CANAL = 2'd1; WR_DUTY = 19'd2; end
         step();
      end
      WR_EN = 1'b0;
   endtask

   task automatic test_limites;
      EN = 1'b0;
      step();
      escribir(0, 0);
      escribir(1, 10);
      escribir(2, 500);
      reiniciar();
      for (int k = 0; k < 25; k++) begin
         checks++; if (PWM_OUT[2:0] !== 3'b110) begin errores++; $display("FAIL limites_pwm k=%0d got=%b exp=110", k, PWM_OUT[2:0]); end
         checks++; if (PENDIENTE !== 1'b0) begin errores++; $display("FAIL limites_pend k=%0d got=%b exp=0", k, PENDIENTE); end
         step();
      end
   endtask

   task automatic test_centrado;
      int  sec[10] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
      logic e;
      EN = 1'b0; PERIODO = 19'd5; CENTRADO = 1'b1;
      step();
      escribir(0, 3);
      escribir(1, 5);
      escribir(2, 1);
      reiniciar();
      for (int k = 0; k < 20; k++) begin
         e = sec[k % 10] < 3;
         checks++; if (PWM_OUT[0] !== e) begin errores++; $display("FAIL centro_pwm0 k=%0d got=%b exp=%b", k, PWM_OUT[0], e); end
         e = sec[k % 10] < 5;
         checks++; if (PWM_OUT[1] !== e) begin errores++; $display("FAIL centro_pwm1 k=%0d got=%b exp=%b", k, PWM_OUT[1], e); end
         e = sec[k % 10] < 1;
         checks++; if (PWM_OUT[2] !== e) begin errores++; $display("FAIL centro_pwm2 k=%0d got=%b exp=%b", k, PWM_OUT[2], e); end
         e = (k % 10) == 0;
         checks++; if (CICLO !== e) begin errores++; $display("FAIL centro_ciclo k=%0d got=%b exp=%b", k, CICLO, e); end
         step();
      end
      PERIODO = 19'd0;
      reiniciar();
      for (int k = 0; k < 8; k++) begin
         checks++; if (PWM_OUT !== 4'b0111) begin errores++; $display("FAIL p0_pwm k=%0d got=%b exp=0111", k, PWM_OUT); end
         checks++; if (CICLO !== 1'b1) begin errores++; $display("FAIL p0_ciclo k=%0d got=%b exp=1", k, CICLO); end
         step();
      end
   endtask

   task automatic test_cambio_periodo;
      int  sec[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
      logic e;
      EN = 1'b0; PERIODO = 19'd9; CENTRADO = 1'b0;
      step();
      reiniciar();
      for (int k = 0; k < 26; k++) begin
         if (k < 10) e = k < 3;
         else        e = sec[(k - 10) % 8] < 3;
         checks++; if (PWM_OUT[0] !== e) begin errores++; $display("FAIL cambio_pwm0 k=%0d got=%b exp=%b", k, PWM_OUT[0], e); end
         if (k < 10) e = (k == 0);
         else        e = ((k - 10) % 8) == 0;
         checks++; if (CICLO !== e) begin errores++; $display("FAIL cambio_ciclo k=%0d got=%b exp=%b", k, CICLO, e); end
         if (k == 3) begin PERIODO = 19'd4; CENTRADO = 1'b1; end
         step();
      end
   endtask

   task automatic test_reset_asinc;
      reiniciar();
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      checks++; if (PWM_OUT !== 4'b0000) begin errores++; $display("FAIL arst_pwm got=%b exp=0000", PWM_OUT); end
      checks++; if (CICLO !== 1'b0) begin errores++; $display("FAIL arst_ciclo got=%b exp=0", CICLO); end
      checks++; if (PENDIENTE !== 1'b0) begin errores++; $display("FAIL arst_pend got=%b exp=0", PENDIENTE); end
      @(negedge CLK);
      @(negedge CLK);
      EN = 1'b1; PERIODO = 19'd4; CENTRADO = 1'b1;
      RST_N = 1'b1;
      step();
      checks++; if (CICLO !== 1'b1) begin errores++; $display("FAIL post_rst_ciclo got=%b exp=1", CICLO); end
      checks++; if (PWM_OUT[0] !== 1'b0) begin errores++; $display("FAIL post_rst_duty0 got=%b exp=0", PWM_OUT[0]); end
      WR_EN = 1'b1; WR_CANAL = 2'd0; WR_DUTY = 19'd3;
      step();
      WR_EN = 1'b0;
      // The reset period is far longer than 20 cycles, so the write stays pending.
      for (int r = 1; r <= 20; r++) begin
         checks++; if (CICLO !== 1'b0) begin errores++; $display("FAIL rst_per_ciclo r=%0d got=%b exp=0", r, CICLO); end
         checks++; if (PWM_OUT[0] !== 1'b0) begin errores++; $display("FAIL rst_per_pwm0 r=%0d got=%b exp=0", r, PWM_OUT[0]); end
         if (r >= 2) begin
            checks++; if (PENDIENTE !== 1'b1) begin errores++; $display("FAIL rst_per_pend r=%0d got=%b exp=1", r, PENDIENTE); end
         end
         step();
      end
      EN = 1'b0;
      step();
      checks++; if (PWM_OUT[0] !== 1'b0) begin errores++; $display("FAIL en_low_pwm0 got=%b exp=0", PWM_OUT[0]); end
      checks++; if (CICLO !== 1'b0) begin errores++; $display("FAIL en_low_ciclo got=%b exp=0", CICLO); end
      EN = 1'b1;
      step();
      checks++; if (CICLO !== 1'b1) begin errores++; $display("FAIL en_up_ciclo got=%b exp=1", CICLO); end
      checks++; if (PWM_OUT[0] !== 1'b1) begin errores++; $display("FAIL en_up_pwm0 got=%b exp=1", PWM_OUT[0]); end
      step();
      checks++; if (PENDIENTE !== 1'b0) begin errores++; $display("FAIL en_up_pend got=%b exp=0", PENDIENTE); end
   endtask

   initial begin
      test_reset();
      test_borde();
      test_escritura();
      test_limites();
      test_centrado();
      test_cambio_periodo();
      test_reset_asinc();
      $display("Result: errors=%0d of %0d checks", errores, checks);
      $finish;
   end

endmodule

// File: doc/pwm_multicanal.md
Name: pwm_multicanal

Overview:
Parametrised successor to the single-channel 1 kHz PWM generator. One shared period counter drives N independent PWM channels. Each channel has a double-buffered duty register, and the period and alignment mode are double-buffered too, so updates take effect only at a period boundary and never glitch. Edge-aligned and centre-aligned modes are supported. It sits between the control/register logic and the motor/LED driver pins.

Parameters:
N_CANALES, 4, number of PWM channels (1..16)
ANCHO, 19, width of counter, period and duty values
PERIODO_RST, 499_999, period value loaded at reset (1 kHz edge-aligned at 500 MHz/… clock per board config)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
EN  in  1  run enable; low holds counter and forces outputs low
PERIODO  in  ANCHO  period value P, sampled only at a boundary
CENTRADO  in  1  0 = edge-aligned, 1 = centre-aligned; sampled only at a boundary
WR_EN  in  1  duty write strobe, single cycle, no back-pressure
WR_CANAL  in  max(1,$clog2(N_CANALES))  channel index for the write
WR_DUTY  in  ANCHO  duty value D for the addressed channel
PWM_OUT  out  N_CANALES  PWM outputs, registered
CICLO  out  1  one-cycle pulse at the start of each period, registered
PENDIENTE  out  1  high while any shadow value differs from the active one (written, not yet applied)

Behaviour:
- Reset (RST_N low, async): counter = 0, direction = up, active and shadow duties = 0, active period = PERIODO_RST, active mode = 0, PWM_OUT = 0, CICLO = 0, PENDIENTE = 0. Reset may assert mid-period; outputs clear immediately.
- Writes: if WR_EN is high, shadow[WR_CANAL] <= WR_DUTY on the next edge. An out-of-range WR_CANAL is ignored. Writes are accepted whether EN is high or low.
- Boundary: the cycle in which the counter returns to 0 on the next edge. At that edge, active period <= PERIODO, active mode <= CENTRADO, and every active duty <= the shadow value. The shadow value is the post-write value, so a write in the boundary cycle is applied in the same update.
- Edge-aligned mode (active mode 0):
  - The counter counts 0,1,…,P, then wraps to 0, giving a period of P+1 cycles.
  - The boundary is at count == P.
- Centre-aligned mode (active mode 1):
  - The counter counts up 0…P, then down P−1…1, then returns to 0, giving a period of 2P cycles.
  - The boundary is at count == 1 while counting down.
  - If P == 0, the counter stays at 0 and every cycle is a boundary.
- Compare and output, for each channel i: PWM_OUT[i](t+1) = EN(t) && (count(t) < D_i,active(t)). This gives one cycle of latency from counter to pin.
  - D = 0 produces a constant low output.
  - In edge mode, D ≥ P+1 produces a constant high output.
  - In centre mode, D > P produces a constant high output.
  - The output is high for D cycles per period in edge mode and 2D−1 cycles in centre mode (D ≥ 1, D ≤ P).
- CICLO(t+1) = EN(t) && count(t) == 0.
- EN low:
  - The counter is forced to 0 with direction up.
  - PWM_OUT and CICLO go to 0 on the next edge.
  - Every cycle with EN low acts as a boundary, so actives continuously track shadows, PERIODO and CENTRADO.
  - On the first cycle with EN high, counting starts from 0 with fresh values.
- A PERIODO or CENTRADO change mid-period has no effect until the boundary. If the new P is below the current count, this is harmless because the counter restarts at 0.
- Arithmetic: unsigned compares, ANCHO bits. The counter never exceeds the active P, so there is no overflow.
- PENDIENTE is a combinational OR across channels of (shadow ≠ active), registered.

Decomposition:
- Shared package: mode encodings (MODO_BORDE = 0, MODO_CENTRADO = 1), default period constant, and the channel-index width function.
- One natural sub-module, pwm_canal: holds the shadow/active duty pair and the registered compare for one channel. It is instantiated N_CANALES times in a generate loop. The top holds the counter, direction and boundary logic.

Test Plan:
1. Reset then EN = 1, P = 9, edge mode, write ch0 D = 3 (while EN low) → ch0 high 3 of every 10 cycles, CICLO every 10 cycles, first PWM_OUT high one cycle after EN.
2. Mid-period write of ch1 D = 7 with P = 9 → no change until the next CICLO, PENDIENTE high until then, then 7/10 duty. Write on the exact boundary cycle → applied at that boundary.
3. Limits with P = 9: D = 0 → constant low; D = 10 and D = 500 → constant high, no single-cycle dips across the wrap.
4. Centre mode, P = 5, D = 3 → count sequence 0..5..1, period 10, output high 5 cycles symmetric about count 0. P = 0 → counter stuck at 0, D ≥ 1 constant high.
5. Change PERIODO 9 → 4 and CENTRADO 0 → 1 mid-period → the old period completes, the new one starts exactly at the boundary.
6. Assert RST_N low asynchronously mid-period (between edges) → all outputs 0 immediately, duties back to 0, period = PERIODO_RST after release; EN dropped mid-period → outputs low on the next edge, restart from count 0.
